// File: rtl/tt_hu8785_acc_pkg.sv
// Shared definitions for the block sum accumulator: FSM encoding, output
// select codes, pin bit positions and the saturating add helper.
package tt_hu8785_acc_pkg;

  // Block FSM; the encoding is visible on the status byte, so it is fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // uo_out select codes (uio_in[3:2])
  localparam logic [1:0] SEL_ACC_LO = 2'd0;
  localparam logic [1:0] SEL_ACC_HI = 2'd1;
  localparam logic [1:0] SEL_COUNT  = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  // uio_in bit positions
  localparam int IN_STROBE = 0;
  localparam int IN_CLEAR  = 1;
  localparam int IN_SEL_LSB = 2;

  // uio_out flag bit positions
  localparam int FLAG_DONE = 7;
  localparam int FLAG_OVF  = 6;
  localparam int FLAG_BUSY = 5;
  localparam int FLAG_ACK  = 4;

  // Upper nibble of uio is driven, lower nibble stays an input.
  localparam logic [7:0] UIO_OE_VALUE = 8'hF0;

  typedef struct packed {
    logic [15:0] sum;
    logic        ovf;
  } sat_sum_t;

  // 16-bit + 8-bit unsigned add that clamps at 16'hFFFF and flags the clamp.
  function automatic sat_sum_t sat_add(input logic [15:0] a, input logic [7:0] b);
    sat_sum_t   res;
    logic [16:0] wide;
    wide    = {1'b0, a} + {9'b0, b};
    res.ovf = wide[16];
    res.sum = wide[16] ? 16'hFFFF : wide[15:0];
    return res;
  endfunction

endpackage

// File: rtl/tt_um_hu8785_sum_accum_if.sv
// Pin bundle of the accumulator tile. The master side drives the sample and
// control pins, the slave side (the tile) drives the result pins.
interface tt_um_hu8785_sum_accum_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_hu8785_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin with a registered
// rising-edge pulse. Edges are suppressed until the pipeline holds only real
// pin samples, so a pin that is already high when reset releases never
// produces an edge.
module tt_hu8785_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   rise_reg;
  // Ones shift in after reset; the top bit marks that level and prev both
  // carry sampled pin values rather than reset zeros.
  logic [SYNC_STAGES:0]   fill_reg;

  // Synchronizer chain, previous-level tracker and registered edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
      fill_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      prev_reg <= sync_reg[SYNC_STAGES-1];
      fill_reg <= {fill_reg[SYNC_STAGES-1:0], 1'b1};
      rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg & fill_reg[SYNC_STAGES];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = rise_reg;

endmodule

// File: rtl/tt_um_hu8785_sum_accum.sv
// Block sum accumulator: adds BLOCK_LEN strobed 8-bit samples into a
// saturating 16-bit sum, then holds the result in DONE until cleared.
module tt_um_hu8785_sum_accum
  import tt_hu8785_acc_pkg::*;
#(
  parameter int BLOCK_LEN   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [7:0] LAST_COUNT = 8'(BLOCK_LEN);

  logic        accept;
  logic        clear_level;
  logic        strobe_level_unused;
  logic        clear_rise_unused;
  logic        unused_pins;
  logic [1:0]  sel;

  state_t      state_reg, state_next;
  logic [15:0] acc_reg, acc_next;
  logic [7:0]  count_reg, count_next;
  logic        ovf_reg, ovf_next;
  logic        ack_reg, ack_next;
  logic        busy_reg, done_reg;
  sat_sum_t    add;

  assign unused_pins = &{1'b0, ena, uio_in[7:4]};
  // Select is a static user setting and only steers the output mux.
  assign sel = uio_in[IN_SEL_LSB +: 2];

  tt_hu8785_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (uio_in[IN_STROBE]),
    .level (strobe_level_unused),
    .rise  (accept)
  );

  tt_hu8785_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clear_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (uio_in[IN_CLEAR]),
    .level (clear_level),
    .rise  (clear_rise_unused)
  );

  // Next-state logic: clear wins over accept; DONE ignores accepts.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    ack_next   = 1'b0;
    add        = sat_add(acc_reg, ui_in);
    if (clear_level) begin
      state_next = ST_IDLE;
      acc_next   = '0;
      count_next = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            acc_next   = {8'h00, ui_in};
            count_next = 8'd1;
            ack_next   = 1'b1;
            state_next = (BLOCK_LEN == 1) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            acc_next   = add.sum;
            ovf_next   = ovf_reg | add.ovf;
            count_next = count_reg + 8'd1;
            ack_next   = 1'b1;
            if (count_next == LAST_COUNT) begin
              state_next = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          acc_next = acc_reg;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State registers; busy/done are registered decodes of the next state so
  // the pins never glitch on state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      ack_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      ack_reg   <= ack_next;
      busy_reg  <= (state_next == ST_RUN);
      done_reg  <= (state_next == ST_DONE);
    end
  end

  // Result byte mux driven straight from the select pins.
  always_comb begin
    uo_out = 8'h00;
    case (sel)
      SEL_ACC_LO: uo_out = acc_reg[7:0];
      SEL_ACC_HI: uo_out = acc_reg[15:8];
      SEL_COUNT:  uo_out = count_reg;
      SEL_STATUS: uo_out = {done_reg, ovf_reg, busy_reg, 3'b000, state_reg};
      default:    uo_out = 8'h00;
    endcase
  end

  // Flag pins on the upper uio nibble; the lower nibble is an input.
  always_comb begin
    uio_out            = 8'h00;
    uio_out[FLAG_DONE] = done_reg;
    uio_out[FLAG_OVF]  = ovf_reg;
    uio_out[FLAG_BUSY] = busy_reg;
    uio_out[FLAG_ACK]  = ack_reg;
  end

  assign uio_oe = UIO_OE_VALUE;

endmodule

// File: tb/tb_tt_um_hu8785_sum_accum.sv
// Randomized bench for the block accumulator: two tiles (BLOCK_LEN 16 and
// 255) see the same pins and are compared against a sum/count model.
module tb_tt_um_hu8785_sum_accum;
  import tt_hu8785_acc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui = 8'h00;
  logic       strobe = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] sel = 2'b00;

  int n_checks = 0;
  int n_fail = 0;
  int ack_cnt [2] = '{0, 0};

  // Model: plain running sum / count per block length.
  int    m_len [2] = '{16, 255};
  int    m_sum [2];
  int    m_cnt [2];
  bit    m_ovf [2];
  bit    exp_ack [2];
  string name [2] = '{"b16", "b255"};
  logic [7:0] rd [2][4];

  always #5 clk = ~clk;

  tt_um_hu8785_sum_accum_if bus16 ();
  tt_um_hu8785_sum_accum_if bus255 ();

  assign bus16.ui_in   = ui;
  assign bus16.uio_in  = {4'b0000, sel, clear, strobe};
  assign bus255.ui_in  = ui;
  assign bus255.uio_in = {4'b0000, sel, clear, strobe};

  tt_um_hu8785_sum_accum #(.BLOCK_LEN(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .ena(1'b1),
    .ui_in(bus16.ui_in), .uio_in(bus16.uio_in),
    .uo_out(bus16.uo_out), .uio_out(bus16.uio_out), .uio_oe(bus16.uio_oe)
  );

  tt_um_hu8785_sum_accum #(.BLOCK_LEN(255), .SYNC_STAGES(2)) dut255 (
    .clk(clk), .rst_n(rst_n), .ena(1'b1),
    .ui_in(bus255.ui_in), .uio_in(bus255.uio_in),
    .uo_out(bus255.uo_out), .uio_out(bus255.uio_out), .uio_oe(bus255.uio_oe)
  );

  // Count ack cycles away from the active edge.
  always @(negedge clk) begin
    if (bus16.uio_out[FLAG_ACK] === 1'b1) ack_cnt[0] <= ack_cnt[0] + 1;
    if (bus255.uio_out[FLAG_ACK] === 1'b1) ack_cnt[1] <= ack_cnt[1] + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sum[i] = 0;
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_accept(input logic [7:0] v);
    for (int i = 0; i < 2; i++) begin
      exp_ack[i] = 1'b0;
      if (m_cnt[i] < m_len[i]) begin
        exp_ack[i] = 1'b1;
        m_cnt[i]++;
        m_sum[i] += int'(v);
        if (m_sum[i] > 65535) begin
          m_sum[i] = 65535;
          m_ovf[i] = 1'b1;
        end
      end
    end
  endtask

  // Read all four select views of both tiles (4 ns, within one low phase).
  task automatic snap();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      rd[0][s] = bus16.uo_out;
      rd[1][s] = bus255.uo_out;
    end
    sel = 2'b00;
  endtask

  task automatic check_all(input string tag);
    snap();
    for (int i = 0; i < 2; i++) begin
      int         st;
      bit         dn, bz;
      logic [7:0] status_exp, flags_exp, flags_got;
      if (m_cnt[i] == 0) st = 0;
      else if (m_cnt[i] == m_len[i]) st = 2;
      else st = 1;
      dn = (st == 2);
      bz = (st == 1);
      status_exp = {dn, m_ovf[i], bz, 3'b000, 2'(st)};
      flags_exp  = {dn, m_ovf[i], bz, 1'b0, 4'b0000};
      flags_got  = (i == 0) ? bus16.uio_out : bus255.uio_out;
      check_eq($sformatf("%s/%s/acc", tag, name[i]), {16'h0, rd[i][1], rd[i][0]}, 32'(m_sum[i]));
      check_eq($sformatf("%s/%s/count", tag, name[i]), {24'h0, rd[i][2]}, 32'(m_cnt[i]));
      check_eq($sformatf("%s/%s/status", tag, name[i]), {24'h0, rd[i][3]}, {24'h0, status_exp});
      check_eq($sformatf("%s/%s/flags", tag, name[i]), {24'h0, flags_got}, {24'h0, flags_exp});
    end
  endtask

  task automatic do_strobe(input logic [7:0] v, input string tag);
    int a0 [2];
    @(negedge clk);
    a0[0] = ack_cnt[0];
    a0[1] = ack_cnt[1];
    ui = v;
    strobe = 1'b1;
    repeat (6) @(negedge clk);
    strobe = 1'b0;
    repeat (4) @(negedge clk);
    model_accept(v);
    check_eq($sformatf("%s/b16/ack", tag), 32'(ack_cnt[0] - a0[0]), {31'h0, exp_ack[0]});
    check_eq($sformatf("%s/b255/ack", tag), 32'(ack_cnt[1] - a0[1]), {31'h0, exp_ack[1]});
    check_all(tag);
    $display("strobe %s v=%02h ack=%0d/%0d acc=%04h/%04h cnt=%0d/%0d", tag, v,
             exp_ack[0], exp_ack[1], m_sum[0], m_sum[1], m_cnt[0], m_cnt[1]);
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    clear = 1'b1;
    repeat (4) @(negedge clk);
    clear = 1'b0;
    repeat (4) @(negedge clk);
    model_reset();
    check_all(tag);
    $display("clear %s", tag);
  endtask

  initial begin
    int a16;
    model_reset();

    // Reset state
    #3;
    check_all("reset");
    check_eq("reset/oe16", {24'h0, bus16.uio_oe}, 32'hF0);
    check_eq("reset/oe255", {24'h0, bus255.uio_oe}, 32'hF0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // First-sample latency: pin high before E0, ack in the cycle after E3
    ui = 8'h05;
    strobe = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_eq($sformatf("lat/ack/e%0d", k - 1), {31'h0, bus16.uio_out[FLAG_ACK]}, (k == 4) ? 32'h1 : 32'h0);
      check_eq($sformatf("lat/acc/e%0d", k - 1), {24'h0, bus16.uo_out}, (k >= 4) ? 32'h5 : 32'h0);
    end
    strobe = 1'b0;
    repeat (4) @(negedge clk);
    model_accept(8'h05);
    check_all("lat");
    $display("latency sample v=05 done");
    do_clear("clr0");

    // Sixteen 0x10 samples complete the 16-sample block
    a16 = ack_cnt[0];
    for (int k = 0; k < 16; k++) do_strobe(8'h10, $sformatf("blk16_%0d", k));
    check_eq("blk16/acks", 32'(ack_cnt[0] - a16), 32'd16);

    // Strobe while DONE is ignored by the 16-sample tile
    do_strobe(8'h7F, "done_ign");
    do_clear("clr1");

    // 255 samples of 0xFF on the 255-sample tile: 0xFE01, no overflow
    for (int k = 0; k < 255; k++) do_strobe(8'hFF, $sformatf("ff_%0d", k));
    do_clear("clr2");

    // Random samples with occasional clears
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) do_clear($sformatf("rclr_%0d", k));
      else do_strobe(8'($urandom_range(0, 255)), $sformatf("rnd_%0d", k));
    end

    // Clear and strobe arrive together: sample dropped, block cleared
    do_clear("clr3");
    do_strobe(8'($urandom_range(1, 255)), "pre_sim");
    begin
      int b0 [2];
      @(negedge clk);
      b0[0] = ack_cnt[0];
      b0[1] = ack_cnt[1];
      ui = 8'h33;
      strobe = 1'b1;
      clear = 1'b1;
      repeat (6) @(negedge clk);
      strobe = 1'b0;
      clear = 1'b0;
      repeat (4) @(negedge clk);
      model_reset();
      check_eq("sim/b16/ack", 32'(ack_cnt[0] - b0[0]), 32'd0);
      check_eq("sim/b255/ack", 32'(ack_cnt[1] - b0[1]), 32'd0);
      check_all("sim");
      $display("clear+strobe together");
    end

    // Saturation: preload near max, then overflow sticks
    do_clear("clr4");
    for (int k = 0; k < 3; k++) do_strobe(8'($urandom_range(0, 255)), $sformatf("pre_ovf_%0d", k));
    @(negedge clk);
    force dut16.acc_reg = 16'hFFF0;
    #1;
    release dut16.acc_reg;
    m_sum[0] = 16'hFFF0;
    @(negedge clk);
    check_all("preload");
    do_strobe(8'h20, "ovf_a");
    do_strobe(8'h01, "ovf_b");

    // Reset mid-block with strobe held through release
    do_clear("clr5");
    for (int k = 0; k < 7; k++) do_strobe(8'($urandom_range(0, 255)), $sformatf("mid_%0d", k));
    begin
      int c0 [2];
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      strobe = 1'b1;
      ui = 8'h44;
      #1;
      check_eq("arst/b16/flags", {24'h0, bus16.uio_out}, 32'h0);
      check_eq("arst/b255/flags", {24'h0, bus255.uio_out}, 32'h0);
      snap();
      for (int i = 0; i < 2; i++)
        for (int s = 0; s < 4; s++)
          check_eq($sformatf("arst/%s/sel%0d", name[i], s), {24'h0, rd[i][s]}, 32'h0);
      check_eq("arst/oe16", {24'h0, bus16.uio_oe}, 32'hF0);
      model_reset();
      repeat (3) @(negedge clk);
      c0[0] = ack_cnt[0];
      c0[1] = ack_cnt[1];
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check_eq("rel/b16/ack", 32'(ack_cnt[0] - c0[0]), 32'd0);
      check_eq("rel/b255/ack", 32'(ack_cnt[1] - c0[1]), 32'd0);
      check_all("rel");
      strobe = 1'b0;
      repeat (4) @(negedge clk);
      $display("reset mid-block, strobe held across release");
    end
    do_strobe(8'h21, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_hu8785_sum_accum.md
TT_UM_HU8785_SUM_ACCUM -- requirements
Module: tt_um_hu8785_sum_accum

Interface
REQ-001 SHALL have parameter BLOCK_LEN, default 16, samples per block (legal 1..255).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flip-flop depth of input synchronizers (legal 2..3).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ena  input  1  power-good; ignored.
REQ-006 ui_in  input  8  unsigned 8-bit sample from the upstream adder stage.
REQ-007 uio_in  input  8  [0] strobe (sample valid), [1] clear (level), [3:2] output select, [7:4] unused.
REQ-008 uo_out  output  8  result byte chosen by select.
REQ-009 uio_out  output  8  [7] done, [6] ovf, [5] busy, [4] ack; [3:0] tied 0.
REQ-010 uio_oe  output  8  constant 8'hF0.

Function
REQ-011 strobe and clear SHALL each pass through a SYNC_STAGES-deep synchronizer; the accept pulse SHALL be the rising edge of the synchronized strobe (one cycle wide).
REQ-012 With SYNC_STAGES=2, a strobe pin rising before clock edge E0 SHALL produce accept during the cycle after E2 and an accumulator update at edge E3.
REQ-013 ui_in SHALL be sampled at the edge where accept is high; the source holds ui_in stable from strobe high until ack.
REQ-014 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE: accept -> acc=ui_in, count=1, go RUN (or DONE if BLOCK_LEN=1).
REQ-016 RUN: accept -> acc=acc+ui_in, count=count+1; go DONE on the accept that makes count==BLOCK_LEN.
REQ-017 DONE: accepts ignored (no ack, no update) until clear.
REQ-018 acc SHALL be 16-bit unsigned, saturating: if acc+ui_in > 16'hFFFF then acc=16'hFFFF and ovf set.
REQ-019 ovf SHALL be sticky until clear or reset.
REQ-020 count SHALL be 8-bit, never exceed BLOCK_LEN.
REQ-021 Synchronized clear high SHALL force IDLE, acc=0, count=0, ovf=0 at the next edge; clear has priority over a simultaneous accept (sample dropped, no ack).
REQ-022 Clear held high SHALL hold the block in IDLE; strobe edges during clear SHALL be discarded.
REQ-023 ack SHALL be a registered one-cycle pulse in the cycle after each accepted (non-ignored) sample.
REQ-024 busy = (state==RUN); done = (state==DONE); both registered-state decodes, glitch-free.
REQ-025 uo_out select: 00 acc[7:0], 01 acc[15:8], 10 count, 11 {done, ovf, busy, 3'b000, state[1:0]}; combinational from select, registered data.
REQ-026 Select SHALL NOT be synchronized; changing it affects uo_out only.

Reset
REQ-027 rst_n low SHALL immediately clear acc, count, ovf, ack, synchronizer flops and set state IDLE, regardless of clock.
REQ-028 Under reset uo_out=8'h00 (select 00/01/10) and 8'h00 (select 11); uio_out=8'h00; uio_oe=8'hF0.
REQ-029 Reset mid-block SHALL discard the partial sum; no ack for a strobe in flight.
REQ-030 First accept after rst_n release SHALL need a fresh strobe rising edge (strobe high through release is not an edge).

Structure
REQ-031 Package tt_hu8785_acc_pkg SHALL hold the FSM state enum, select codes, and uio_out flag bit positions.
REQ-032 Sub-module tt_hu8785_sync_edge (SYNC_STAGES synchronizer, level and rising-edge outputs) SHALL be instantiated for strobe and for clear.
REQ-033 Target 150-250 lines RTL total; no latches, no gated clocks.

Verification
REQ-034 Reset then 16 strobes with ui_in=8'h10 -> acc=16'h0100, count=16, done=1, busy=0, 16 ack pulses.
REQ-035 Strobe pin high at E0 with ui_in=8'h05 after reset -> accept after E2, acc=5 visible after E3, ack high for the cycle after E3.
REQ-036 BLOCK_LEN=255, 255 strobes of 8'hFF -> acc=16'hFE01, ovf=0; BLOCK_LEN=16 after preload near max (override) -> acc=16'hFFFF, ovf=1, stays 1.
REQ-037 In DONE, strobe with ui_in=8'h7F -> no ack, acc unchanged; clear -> IDLE, acc=0, ovf=0.
REQ-038 Clear and strobe synchronized-edge in the same cycle -> no ack, acc=0, state IDLE.
REQ-039 rst_n pulsed low mid-block (count=7) -> outputs zero asynchronously; strobe held high across release gives no accept.
